nzcv_branch_resolver: RTL and testbench

//  Consumer end of the ALU flag interface. Holds the architectural NZCV flags produced by the
//  64-bit add/sub datapath, forwards in-flight flags, and resolves B.cond / CBZ / CBNZ in the ID

---
 rtl/cpu_flags_pkg.sv | 58 +++++
 rtl/cond_eval.sv | 37 +++
 rtl/nzcv_branch_resolver.sv | 146 ++++++++++++++
 tb/tb_nzcv_branch_resolver.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_flags_pkg.sv
// Shared flag, condition-code and branch-kind types for the ALU flag consumer
// and the datapath blocks that reuse condition evaluation.
package cpu_flags_pkg;

    // Bit order matches the {N,Z,C,V} flag bus.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    typedef enum logic [3:0] {
        CondEq = 4'd0,
        CondNe = 4'd1,
        CondHs = 4'd2,
        CondLo = 4'd3,
        CondMi = 4'd4,
        CondPl = 4'd5,
        CondVs = 4'd6,
        CondVc = 4'd7,
        CondHi = 4'd8,
        CondLs = 4'd9,
        CondGe = 4'd10,
        CondLt = 4'd11,
        CondGt = 4'd12,
        CondLe = 4'd13,
        CondAl = 4'd14,
        CondNv = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        BrCond   = 2'd0,
        BrCbz    = 2'd1,
        BrCbnz   = 2'd2,
        BrUncond = 2'd3
    } br_kind_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StFlush = 1'b1
    } br_state_e;

    function automatic logic kind_taken(input br_kind_e kind,
                                        input logic     cond_taken,
                                        input logic     rt_zero);
        logic taken;
        taken = 1'b0;
        unique case (kind)
            BrCond:   taken = cond_taken;
            BrCbz:    taken = rt_zero;
            BrCbnz:   taken = ~rt_zero;
            BrUncond: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Pure combinational ARM condition-code evaluator: flags + condition -> holds.
// Shared between branch resolution and the conditional-select datapath.
module cond_eval
    import cpu_flags_pkg::*;
(
    input  nzcv_t flags_i,
    input  cond_e cond_i,
    output logic  taken_o
);

    logic n_eq_v;

    assign n_eq_v = (flags_i.n == flags_i.v);

    always_comb begin
        taken_o = 1'b0;
        unique case (cond_i)
            CondEq: taken_o = flags_i.z;
            CondNe: taken_o = ~flags_i.z;
            CondHs: taken_o = flags_i.c;
            CondLo: taken_o = ~flags_i.c;
            CondMi: taken_o = flags_i.n;
            CondPl: taken_o = ~flags_i.n;
            CondVs: taken_o = flags_i.v;
            CondVc: taken_o = ~flags_i.v;
            CondHi: taken_o = flags_i.c & ~flags_i.z;
            CondLs: taken_o = ~flags_i.c | flags_i.z;
            CondGe: taken_o = n_eq_v;
            CondLt: taken_o = ~n_eq_v;
            CondGt: taken_o = ~flags_i.z & n_eq_v;
            CondLe: taken_o = flags_i.z | ~n_eq_v;
            CondAl: taken_o = 1'b1;
            CondNv: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/nzcv_branch_resolver.sv
// ID-stage branch resolver: architectural NZCV register with EX forwarding,
// B.cond/CBZ/CBNZ/B resolution, IF flush control and a multi-cycle flag tracker.
module nzcv_branch_resolver
    import cpu_flags_pkg::*;
#(
    parameter int unsigned McLat       = 3,
    parameter int unsigned FlushCycles = 1
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       ex_valid_i,
    input  logic       ex_setflags_i,
    input  logic [3:0] ex_nzcv_i,
    input  logic       mc_start_i,
    input  logic [3:0] mc_nzcv_i,
    input  logic       br_valid_i,
    input  logic [1:0] br_kind_i,
    input  logic [3:0] br_cond_i,
    input  logic       br_rt_zero_i,
    output logic       br_stall_o,
    output logic       br_taken_o,
    output logic       flush_o,
    output logic [3:0] nzcv_o,
    output logic       mc_busy_o
);

    localparam int unsigned McCntW    = $clog2(McLat + 1);
    localparam int unsigned FlushCntW = $clog2(FlushCycles + 1);

    nzcv_t                nzcv_q, nzcv_d;
    nzcv_t                ex_flags, mc_flags, eff_flags;
    logic                 ex_wr;

    logic [McCntW-1:0]    mc_cnt_q, mc_cnt_d;
    logic                 mc_busy_q, mc_busy_d;
    logic                 mc_done;

    br_state_e            state_q, state_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
    logic                 br_taken_q, br_taken_d;
    logic                 flush_q, flush_d;

    br_kind_e             kind;
    cond_e                cond;
    logic                 cond_taken;
    logic                 in_flush;
    logic                 accept;
    logic                 take;

    assign ex_flags  = nzcv_t'(ex_nzcv_i);
    assign mc_flags  = nzcv_t'(mc_nzcv_i);
    assign ex_wr     = ex_valid_i & ex_setflags_i;
    assign eff_flags = ex_wr ? ex_flags : nzcv_q;

    assign kind = br_kind_e'(br_kind_i);
    assign cond = cond_e'(br_cond_i);

    cond_eval u_cond_eval (
        .flags_i (eff_flags),
        .cond_i  (cond),
        .taken_o (cond_taken)
    );

    // A restart on the completion cycle drops the older result.
    assign mc_done = mc_busy_q & (mc_cnt_q == McCntW'(1)) & ~mc_start_i;

    always_comb begin
        mc_busy_d = mc_busy_q;
        mc_cnt_d  = mc_cnt_q;
        if (mc_start_i) begin
            mc_busy_d = 1'b1;
            mc_cnt_d  = McCntW'(McLat);
        end else if (mc_busy_q) begin
            mc_cnt_d = mc_cnt_q - McCntW'(1);
            if (mc_done) begin
                mc_busy_d = 1'b0;
            end
        end
    end

    // Younger EX write overrides a coincident multi-cycle completion.
    always_comb begin
        nzcv_d = nzcv_q;
        if (mc_done) begin
            nzcv_d = mc_flags;
        end
        if (ex_wr) begin
            nzcv_d = ex_flags;
        end
    end

    // Branches arriving during a flush are squashed slots: never stalled or taken.
    assign in_flush   = (state_q == StFlush);
    assign br_stall_o = br_valid_i & (kind == BrCond) & mc_busy_q & ~in_flush;
    assign accept     = br_valid_i & ~br_stall_o & ~in_flush;
    assign take       = accept & kind_taken(kind, cond_taken, br_rt_zero_i);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushCntW'(FlushCycles);
                end
            end
            StFlush: begin
                if (flush_cnt_q == FlushCntW'(1)) begin
                    state_d     = StIdle;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FlushCntW'(1);
                end
            end
        endcase
        br_taken_d = take;
        flush_d    = (state_d == StFlush);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            nzcv_q      <= '0;
            mc_cnt_q    <= '0;
            mc_busy_q   <= 1'b0;
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            br_taken_q  <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            nzcv_q      <= nzcv_d;
            mc_cnt_q    <= mc_cnt_d;
            mc_busy_q   <= mc_busy_d;
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            br_taken_q  <= br_taken_d;
            flush_q     <= flush_d;
        end
    end

    assign br_taken_o = br_taken_q;
    assign flush_o    = flush_q;
    assign nzcv_o     = nzcv_q;
    assign mc_busy_o  = mc_busy_q;

endmodule

// File: tb/tb_nzcv_branch_resolver.sv
// Scoreboard bench for nzcv_branch_resolver: driver pushes hand-computed output
// snapshots per cycle, a monitor pops and compares them on each falling edge.
module tb_nzcv_branch_resolver;

    logic       clk;
    logic       reset_n;
    logic       ex_valid, ex_setflags, mc_start, br_valid, br_rt_zero;
    logic [3:0] ex_nzcv, mc_nzcv, br_cond;
    logic [1:0] br_kind;
    logic       br_stall, br_taken, flush, mc_busy;
    logic [3:0] nzcv;

    typedef struct packed {
        logic [7:0] bits;  // {stall, taken, flush, nzcv[3:0], busy}
        logic [7:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   tag_cnt = 0;

    nzcv_branch_resolver #(
        .McLat       (3),
        .FlushCycles (1)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .ex_valid_i    (ex_valid),
        .ex_setflags_i (ex_setflags),
        .ex_nzcv_i     (ex_nzcv),
        .mc_start_i    (mc_start),
        .mc_nzcv_i     (mc_nzcv),
        .br_valid_i    (br_valid),
        .br_kind_i     (br_kind),
        .br_cond_i     (br_cond),
        .br_rt_zero_i  (br_rt_zero),
        .br_stall_o    (br_stall),
        .br_taken_o    (br_taken),
        .flush_o       (flush),
        .nzcv_o        (nzcv),
        .mc_busy_o     (mc_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the oldest expected snapshot at every falling edge.
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {br_stall, br_taken, flush, nzcv, mc_busy};
                n_vec++;
                if (act !== e.bits) begin
                    n_bad++;
                    $display("FAIL vec%0d: got %b want %b (stall,taken,flush,nzcv,busy)",
                             e.tag, act, e.bits);
                end
            end
        end
    end

    // ex = {valid, setflags, nzcv}; mc = {start, nzcv}; br = {valid, kind, cond, rt_zero}
    task automatic cyc(input logic rn, input logic [5:0] ex, input logic [4:0] mc,
                       input logic [7:0] br, input logic [7:0] expv);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n     = rn;
        ex_valid    = ex[5];
        ex_setflags = ex[4];
        ex_nzcv     = ex[3:0];
        mc_start    = mc[4];
        mc_nzcv     = mc[3:0];
        br_valid    = br[7];
        br_kind     = br[6:5];
        br_cond     = br[4:1];
        br_rt_zero  = br[0];
        e.bits      = expv;
        e.tag       = 8'(tag_cnt);
        tag_cnt++;
        exp_q.push_back(e);
    endtask

    initial begin
        reset_n = 1'b0;
        ex_valid = 1'b0; ex_setflags = 1'b0; ex_nzcv = 4'h0;
        mc_start = 1'b0; mc_nzcv = 4'h0;
        br_valid = 1'b0; br_kind = 2'd0; br_cond = 4'h0; br_rt_zero = 1'b0;
        repeat (2) @(posedge clk);

        cyc(0, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_0_0_0000_0); // 0 reset state
        // SUBS 5-5 forwarded into B.EQ
        cyc(1, 6'b11_0100, 5'b0_0000, 8'b1_00_0000_0, 8'b0_0_0_0000_0); // 1
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_1_1_0100_0); // 2 taken+flush
        // nzcv <= 1000, then B.LT taken, B.GE not taken, B.AL taken
        cyc(1, 6'b11_1000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_0_0_0100_0); // 3
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b1_00_1011_0, 8'b0_0_0_1000_0); // 4 B.LT
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_1_1_1000_0); // 5
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b1_00_1010_0, 8'b0_0_0_1000_0); // 6 B.GE
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b1_00_1110_0, 8'b0_0_0_1000_0); // 7 B.AL
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_1_1_1000_0); // 8
        // B then B.AL in the squashed slot: single pulse
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b1_11_0000_0, 8'b0_0_0_1000_0); // 9 B
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b1_00_1110_0, 8'b0_1_1_1000_0); // 10 squashed
        // CBZ taken, CBNZ not taken (rt == 0)
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b1_01_0000_1, 8'b0_0_0_1000_0); // 11 CBZ
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_1_1_1000_0); // 12
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b1_10_0000_1, 8'b0_0_0_1000_0); // 13 CBNZ
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_0_0_1000_0); // 14
        // Multi-cycle op 0001, B.VS stalls three cycles then taken
        cyc(1, 6'b00_0000, 5'b1_0001, 8'b0_00_0000_0, 8'b0_0_0_1000_0); // 15
        cyc(1, 6'b00_0000, 5'b0_0001, 8'b1_00_0110_0, 8'b1_0_0_1000_1); // 16
        cyc(1, 6'b00_0000, 5'b0_0001, 8'b1_00_0110_0, 8'b1_0_0_1000_1); // 17
        cyc(1, 6'b00_0000, 5'b0_0001, 8'b1_00_0110_0, 8'b1_0_0_1000_1); // 18 completion
        cyc(1, 6'b00_0000, 5'b0_0001, 8'b1_00_0110_0, 8'b0_0_0_0001_0); // 19
        cyc(1, 6'b00_0000, 5'b0_0001, 8'b0_00_0000_0, 8'b0_1_1_0001_0); // 20
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_0_0_0001_0); // 21
        // CBNZ never stalls while busy; EX write 0010 beats completion 1000
        cyc(1, 6'b00_0000, 5'b1_1000, 8'b0_00_0000_0, 8'b0_0_0_0001_0); // 22
        cyc(1, 6'b00_0000, 5'b0_1000, 8'b1_10_0000_0, 8'b0_0_0_0001_1); // 23
        cyc(1, 6'b00_0000, 5'b0_1000, 8'b0_00_0000_0, 8'b0_1_1_0001_1); // 24
        cyc(1, 6'b11_0010, 5'b0_1000, 8'b0_00_0000_0, 8'b0_0_0_0001_1); // 25
        cyc(1, 6'b00_0000, 5'b0_0000, 8'b0_00_0000_0, 8'b0_0_0_0010_0); // 26
        // Reset while busy and flushing: cleared without a clock edge
        cyc(1, 6'b00_0000, 5'b1_1111, 8'b0_00_0000_0, 8'b0_0_0_0010_0); // 27
        cyc(1, 6'b00_0000, 5'b0_1111, 8'b1_11_0000_0, 8'b0_0_0_0010_1); // 28
        cyc(0, 6'b00_0000, 5'b0_1111, 8'b0_00_0000_0, 8'b0_0_0_0000_0); // 29
        cyc(0, 6'b00_0000, 5'b0_1111, 8'b0_00_0000_0, 8'b0_0_0_0000_0); // 30
        cyc(1, 6'b00_0000, 5'b0_1111, 8'b0_00_0000_0, 8'b0_0_0_0000_0); // 31
        cyc(1, 6'b00_0000, 5'b0_1111, 8'b0_00_0000_0, 8'b0_0_0_0000_0); // 32
        cyc(1, 6'b00_0000, 5'b0_1111, 8'b0_00_0000_0, 8'b0_0_0_0000_0); // 33
        cyc(1, 6'b00_0000, 5'b0_1111, 8'b0_00_0000_0, 8'b0_0_0_0000_0); // 34

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d snapshots left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
